// File: rtl/hdmi_bitmap_scanout.sv
// hdmi_bitmap_scanout: raster timing, bitmap byte fetch and 1/2/4 bpp expansion to RGB; define SCANOUT_PALETTE_EN for a 16-entry palette
module hdmi_bitmap_scanout #(
  parameter int H_ACTIVE = 640, H_FP = 16, H_SYNC = 96, H_BP = 48,
  parameter int V_ACTIVE = 480, V_FP = 10, V_SYNC = 2, V_BP = 33,
  parameter int BMP_W = 256, BMP_H = 256,
  parameter int BPP = 1, SCALE = 1,
  parameter int ADDR_W = 13,
  parameter logic [23:0] FG_RGB = 24'hFFFFFF, BG_RGB = 24'h000000, BORDER_RGB = 24'h000000
) (
  input  logic              clk_pixel,
  input  logic              reset,
`ifdef SCANOUT_PALETTE_EN
  input  logic              pal_we,
  input  logic [3:0]        pal_idx,
  input  logic [23:0]       pal_rgb,
`endif
  output logic [ADDR_W-1:0] dispAddr,
  input  logic [7:0]        dispData,
  output logic [23:0]       rgb,
  output logic              de,
  output logic              hsync,
  output logic              vsync,
  output logic              frame_start
);
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int CW = $clog2(HT);
  localparam int VW = $clog2(VT);
  localparam int PPB = 8 / BPP;
  localparam int PS = $clog2(PPB);
  localparam int SS = $clog2(SCALE);
  localparam int BPL = BMP_W / PPB;
  localparam logic [CW-1:0] HL = CW'(HT - 1);
  localparam logic [CW-1:0] HA = CW'(H_ACTIVE);
  localparam logic [CW-1:0] HS0 = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS1 = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] BW = CW'(BMP_W * SCALE);
  localparam logic [VW-1:0] VL = VW'(VT - 1);
  localparam logic [VW-1:0] VA = VW'(V_ACTIVE);
  localparam logic [VW-1:0] VS0 = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] VS1 = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] BH = VW'(BMP_H * SCALE);

  logic [CW-1:0] cx, nx;
  logic [VW-1:0] cy, ny;
  logic ld1, act1, win1, hs1, vs1, fs1;
  logic act2, win2, hs2, vs2, fs2;
  logic [PS-1:0] fld1, fld2;
  logic [7:0] bt;
  logic [BPP-1:0] pix;
  logic [23:0] col;

`ifdef SCANOUT_PALETTE_EN
  logic [23:0] pal [16];
  // palette file: BG/FG then greys after reset, host writes land on the strobe edge
  always_ff @(posedge clk_pixel) begin
    if (reset) for (int i = 0; i < 16; i++) pal[i] <= (i == 0) ? BG_RGB : (i == 1) ? FG_RGB : {3{4'(i), 4'(i)}};
    else if (pal_we) pal[pal_idx] <= pal_rgb;
  end
`endif

  // next raster position, shared by the counters and the one-ahead fetch address
  always_comb begin
    nx = (cx == HL) ? '0 : cx + 1'b1;
    ny = (cx != HL) ? cy : (cy == VL) ? '0 : cy + 1'b1;
  end

  // stage 1: counters, fetch address issued as cx enters a byte so data returns in time, position flags
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      cx <= '0;
      cy <= '0;
      dispAddr <= '0;
      {ld1, act1, win1, hs1, vs1, fs1} <= '0;
      fld1 <= '0;
    end else begin
      cx <= nx;
      cy <= ny;
      if (nx < BW && ny < BH && nx[SS+PS-1:0] == '0)
        dispAddr <= ADDR_W'(ny >> SS) * ADDR_W'(BPL) + ADDR_W'(nx >> (SS + PS));
      act1 <= cx < HA && cy < VA;
      win1 <= cx < BW && cy < BH;
      ld1 <= cx < BW && cy < BH && cx[SS+PS-1:0] == '0;
      fld1 <= cx[SS +: PS];
      hs1 <= cx >= HS0 && cx < HS1;
      vs1 <= cy >= VS0 && cy < VS1;
      fs1 <= cx == '0 && cy == '0;
    end
  end

  // stage 2: capture the RAM byte at its first pixel and carry the flags along
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      bt <= '0;
      fld2 <= '0;
      {act2, win2, hs2, vs2, fs2} <= '0;
    end else begin
      if (ld1) bt <= dispData;
      fld2 <= fld1;
      {act2, win2, hs2, vs2, fs2} <= {act1, win1, hs1, vs1, fs1};
    end
  end

  // field select and colour lookup for the pixel in stage 2
  always_comb begin
    pix = bt[3'(fld2 * BPP) +: BPP];
`ifdef SCANOUT_PALETTE_EN
    col = pal[4'(pix)];
`else
    col = (BPP == 1) ? (pix[0] ? FG_RGB : BG_RGB) : {3{{PPB{pix}}}};
`endif
  end

  // stage 3: registered video outputs, border outside the bitmap, black in blanking
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      rgb <= '0;
      {de, hsync, vsync, frame_start} <= '0;
    end else begin
      rgb <= act2 ? (win2 ? col : BORDER_RGB) : '0;
      {de, hsync, vsync, frame_start} <= {act2, hs2, vs2, fs2};
    end
  end
endmodule

// File: doc/hdmi_bitmap_scanout.md
# hdmi_bitmap_scanout

Parametrised bitmap scan-out engine for the HDMI video path. It generates raster timing, fetches packed pixel bytes from a synchronous display RAM, and expands them at 1/2/4 bits per pixel with integer pixel replication. It drives registered 24-bit RGB plus DE/HSYNC/VSYNC straight into the three TMDS encoders. It is the successor of the fixed 640x480, 1 bpp, 256x256 Orao graphics scan-out, and serialisation stays outside this block.

## Interface
Parameters:
- H_ACTIVE, 640; H_FP, 16; H_SYNC, 96; H_BP, 48: horizontal timing in pixels.
- V_ACTIVE, 480; V_FP, 10; V_SYNC, 2; V_BP, 33: vertical timing in lines.
- BMP_W, 256; BMP_H, 256: bitmap size in source pixels.
- BPP, 1: bits per pixel (1, 2 or 4). BMP_W*BPP must be a multiple of 8.
- SCALE, 1: replication factor (1, 2 or 4), applied to both axes. BMP_W*SCALE ≤ H_ACTIVE and BMP_H*SCALE ≤ V_ACTIVE.
- ADDR_W, 13: display RAM address width.
- FG_RGB, 24'hFFFFFF; BG_RGB, 24'h000000; BORDER_RGB, 24'h000000: colours.

Ports:
- clk_pixel  in  1  pixel clock. This is the only clock.
- reset  in  1  synchronous, active-high.
- dispAddr  out  ADDR_W  RAM byte address. Registered.
- dispData  in  8  RAM byte. Valid exactly 1 cycle after dispAddr.
- rgb  out  24  {R,G,B} pixel.
- de  out  1  active-video enable.
- hsync  out  1  active-high.
- vsync  out  1  active-high.
- frame_start  out  1  one-cycle pulse with the first active pixel of each frame.
- pal_we  in  1  palette write strobe. Present only with SCANOUT_PALETTE_EN.
- pal_idx  in  4  palette entry. Present only with SCANOUT_PALETTE_EN.
- pal_rgb  in  24  palette data. Present only with SCANOUT_PALETTE_EN.

## Operation
- Counters: cx runs 0..H_TOTAL-1 (H_TOTAL = sum of the H_ parameters); cy runs 0..V_TOTAL-1 and advances when cx wraps. The active area is cx<H_ACTIVE and cy<V_ACTIVE.
- Sync windows:
  - hsync is asserted for H_ACTIVE+H_FP ≤ cx < H_ACTIVE+H_FP+H_SYNC.
  - vsync uses the same rule with the V_ parameters.
- Bitmap window: top-left aligned, cx<BMP_W*SCALE and cy<BMP_H*SCALE. Active pixels outside the window show BORDER_RGB. Blanking shows rgb=0.
- Packing: PPB = 8/BPP pixels per byte, least-significant field first. Source line L = cy/SCALE. Byte address = L*(BMP_W/PPB) + cx/(PPB*SCALE).
- Addressing: dispAddr is updated only when cx crosses a byte boundary inside the window; otherwise it holds its value. Within the SCALE repeats of one source line, the same addresses are reissued.
- Colour mapping without palette:
  - 1 bpp: 0 maps to BG_RGB, 1 maps to FG_RGB.
  - 2 bpp: index i gives grey {i,i,i,i} on all three channels.
  - 4 bpp: index i gives grey {i,i} on all three channels.
- Reset: on the cycle reset is sampled high, cx and cy return to 0. Registered outputs take their reset values on that clock edge: rgb=0, de=0, hsync=0, vsync=0, frame_start=0, dispAddr=0. Outputs stay at those values for the whole reset plus the pipeline fill, then the frame restarts cleanly at (0,0). Reset mid-frame produces no partial pixels.

## Timing
- Fixed latency of 3 clocks from counter position (cx,cy) to the rgb/de/hsync/vsync for that position. All four outputs are delayed equally, so they stay mutually aligned.
- Stage 1: dispAddr is registered when cx reaches a byte boundary.
- Stage 2: dispData is captured into the shift register.
- Stage 3: the pixel field is mapped to colour and registered onto rgb.
- Each captured byte feeds PPB*SCALE consecutive output pixels. The next byte loads on the cycle the last field of the current byte is consumed, so there are no bubbles.
- frame_start is high exactly when de first rises after vsync, i.e. output position (0,0).
- Counter wrap (cx=H_TOTAL-1 → 0, cy=V_TOTAL-1 → 0) takes one cycle and has no idle slot.

## Configuration
- SCANOUT_PALETTE_EN defined:
  - A 16×24-bit palette register file is present. Pixel index i outputs pal[i]; 1 bpp uses entries 0 and 1.
  - A palette write when pal_we=1 lands on that edge. It affects pixels reaching stage 3 from the next cycle onward, and is allowed during active video.
  - Reset values: pal[0]=BG_RGB, pal[1]=FG_RGB, pal[i]={3{i,i}} for i≥2.
- SCANOUT_PALETTE_EN undefined: there is no palette storage and no pal_* ports; the fixed mapping above applies.

## Test plan
- Default parameters, RAM byte k = k[7:0]. Check:
  - 800×525 totals and hsync high for 96 cycles;
  - dispAddr advances 0..31 per line and reaches 8191 on line 255;
  - pixel (8,0) = FG_RGB (byte 1, bit 0).
- BPP=2, SCALE=2, RAM all 8'hE4. Output columns 0-7 must read grey 00,00,55,55,AA,AA,FF,FF. Lines 0 and 1 must issue identical address sequences.
- Border check: column 512, line 100 = BORDER_RGB with de=1. Column 700 = rgb 0 with de=0. Line 300 in the active area = BORDER_RGB.
- Alignment: over a full frame, de/hsync/vsync/rgb edges must sit exactly 3 cycles after the corresponding counter edges, and frame_start must pulse once per frame, coincident with the first de rise.
- Reset asserted for 5 cycles at cx=300, cy=200. All outputs must be 0 during reset. After release, the first frame_start must come exactly 3 + (V_TOTAL*H_TOTAL) cycles later, or at the 3-cycle point if (0,0) is the restart position.
- With SCANOUT_PALETTE_EN: write pal[1]=24'h123456 mid-line. FG pixels after the write must read 123456, and earlier pixels must stay FFFFFF.
